ctrl_seq: RTL and testbench
===========================

# ctrl_seq

Two-phase fetch/execute sequencer for the 4-bit CPU, sitting directly downstream of the program counter.
- Consumes `PC_CURR` and the instruction word read at that address.
- Latches the instruction, decodes it, and drives the datapath strobes.
- Closes the loop back into the PC through `set_pc`/`PC_INIT` to handle reset, jumps, stalls and halt.
- The PC has no enable or reset, so every hold is a reload of `PC_CURR`, and every reset is a load of 0.

## Interface

Parameters:
- none (4-bit address and 8-bit instruction widths are fixed by the ISA)

Ports:
- `clk`  in  1  single clock; all state updates on its rising edge
- `rst`  in  1  synchronous, active-high reset
- `PC_CURR`  in  4  current PC value
- `INSTR`  in  8  instruction at address `PC_CURR` (combinational ROM read); `[7:4]` opcode, `[3:0]` operand
- `zero`  in  1  ALU zero flag, combinational, valid in EXEC
- `set_pc`  out  1  PC load select: 1 loads `PC_INIT`, 0 increments
- `PC_INIT`  out  4  PC load value
- `IMM`  out  4  operand field of the latched instruction, `IR[3:0]`
- `OPCODE`  out  4  opcode field of the latched instruction, `IR[7:4]`
- `alu_en`  out  1  ALU operation strobe
- `reg_we`  out  1  accumulator write strobe
- `halted`  out  1  high while in HALT

## Operation

State register and instruction register:
- States: FETCH, EXEC, HALT.
- IR is an 8-bit register.

Reset:
- While `rst`=1, outputs are forced combinationally: `set_pc`=1, `PC_INIT`=0, strobes 0, `halted`=0.
- The PC is therefore 0 after the first edge with `rst` high.
- On that edge, state becomes FETCH and IR becomes 8'h00.

FETCH:
- IR <= `INSTR`.
- Hold the PC: `set_pc`=1, `PC_INIT`=`PC_CURR`.
- Strobes are 0.
- Next state: EXEC.

EXEC (decodes IR; default is `set_pc`=0 so the PC increments; next state FETCH unless noted):
- 0x0 NOP: no strobes.
- 0x1 LDI: `reg_we`=1; the datapath selects `IMM`.
- 0x2 ADD: `alu_en`=1, `reg_we`=1.
- 0x3 JMP: `set_pc`=1, `PC_INIT`=`IMM`.
- 0x4 JZ:
  - `zero`=1: same as JMP.
  - `zero`=0: increment.
- 0xF HLT: `set_pc`=1, `PC_INIT`=`PC_CURR`; next state HALT.
- Other opcodes: treated as NOP.

HALT:
- `set_pc`=1, `PC_INIT`=`PC_CURR`, `halted`=1, strobes 0.
- Remains in HALT until `rst`.

Arithmetic and width rules:
- No arithmetic is done inside this block; increment happens in the PC adder.
- PC wrap-around 15 -> 0 is the natural 4-bit overflow and needs no special handling.
- A JMP/JZ target equal to the current PC is legal and produces a tight 2-cycle loop.

## Timing

- 2 cycles per instruction: the PC changes only on the EXEC edge.
- `OPCODE`, `IMM`: registered, valid from the FETCH edge through the following EXEC cycle.
- `set_pc`, `PC_INIT`, `alu_en`, `reg_we`: combinational from state, IR, `PC_CURR`, `zero` and `rst`. They must settle within one cycle, before the PC register setup window.
- `reg_we` and `alu_en` are single-cycle pulses, asserted only in EXEC.
- `zero` is sampled combinationally in the EXEC cycle of JZ; the flag from the previous instruction's EXEC must already be registered by the datapath.
- Reset priority:
  - `rst` overrides every state, including HALT and mid-EXEC.
  - An instruction in EXEC when `rst` rises is aborted: no strobes, and the PC is loaded with 0.
- Reset values:
  - `set_pc`=1, `PC_INIT`=0 while `rst`=1.
  - After the reset edge: `OPCODE`=0, `IMM`=0, `alu_en`=0, `reg_we`=0, `halted`=0.

## Test plan

- Reset: hold `rst` for 1 cycle with the PC at arbitrary 4'hA -> PC=0 after the edge; state FETCH; `halted`=0; `set_pc`=1 during `rst`.
- Sequential run: ROM[0..2]={0x13,0x25,0x00} -> PC steps 0,0,1,1,2,2.
  - `reg_we` pulses in cycles 2 and 4.
  - `alu_en` pulses only in cycle 4.
  - `IMM`=3 then 5.
- JMP and wrap: ROM[15]=0x00, ROM[0]=0x3F -> PC 15 -> 0 by increment, then JMP to 15.
  - Resulting loop period is 4 cycles.
- JZ: ROM[2]=0x49.
  - `zero`=1 in EXEC -> PC=9.
  - `zero`=0 -> PC=3.
- Halt: ROM[4]=0xF0 -> `halted`=1 from the EXEC edge; PC stays 4 for at least 10 cycles; no strobes; `rst` then returns PC to 0 and `halted` to 0.
- Reset mid-EXEC of ADD -> no `alu_en`/`reg_we` pulse in that cycle; PC=0 after the edge.

Source files
------------

// File: rtl/ctrl_seq_if.sv
// Sequencer <-> PC/ROM/datapath bundle; master is the sequencer, slave is the datapath side.
// PC_INIT/set_pc close the loop into a PC register that has no enable or reset of its own.
interface ctrl_seq_if;
  logic [3:0] PC_CURR;
  logic [7:0] INSTR;
  logic       zero;
  logic       set_pc;
  logic [3:0] PC_INIT;
  logic [3:0] IMM;
  logic [3:0] OPCODE;
  logic       alu_en;
  logic       reg_we;
  logic       halted;

  modport master (
    input  PC_CURR, INSTR, zero,
    output set_pc, PC_INIT, IMM, OPCODE, alu_en, reg_we, halted
  );

  modport slave (
    output PC_CURR, INSTR, zero,
    input  set_pc, PC_INIT, IMM, OPCODE, alu_en, reg_we, halted
  );
endinterface

// File: rtl/ctrl_seq.sv
// Two-phase fetch/execute sequencer: 2 cycles per instruction, PC moves only on the EXEC edge.
// No backpressure; holds are PC reloads, rst forces a load of 0 and aborts any EXEC.
module ctrl_seq (
  input  logic       clk,
  input  logic       rst,
  ctrl_seq_if.master bus
);

  typedef enum logic [1:0] {
    FETCH = 2'd0,
    EXEC  = 2'd1,
    HALT  = 2'd2
  } state_t;

  localparam logic [3:0] OP_LDI = 4'h1;
  localparam logic [3:0] OP_ADD = 4'h2;
  localparam logic [3:0] OP_JMP = 4'h3;
  localparam logic [3:0] OP_JZ  = 4'h4;
  localparam logic [3:0] OP_HLT = 4'hF;

  state_t     state_q;
  state_t     state_nxt;
  logic [7:0] ir_q;

  logic       set_pc;
  logic [3:0] pc_init;
  logic       alu_en;
  logic       reg_we;
  logic       halted;

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= FETCH;
      ir_q    <= 8'h00;
    end else begin
      state_q <= state_nxt;
      if (state_q == FETCH) begin
        ir_q <= bus.INSTR;
      end
    end
  end

  always_comb begin
    state_nxt = state_q;
    set_pc    = 1'b0;
    pc_init   = 4'h0;
    alu_en    = 1'b0;
    reg_we    = 1'b0;
    halted    = 1'b0;
    if (rst) begin
      // Reset wins over every state, so an in-flight EXEC never strobes.
      set_pc    = 1'b1;
      pc_init   = 4'h0;
      state_nxt = FETCH;
    end else begin
      case (state_q)
        FETCH: begin
          set_pc    = 1'b1;
          pc_init   = bus.PC_CURR;
          state_nxt = EXEC;
        end
        EXEC: begin
          state_nxt = FETCH;
          case (ir_q[7:4])
            OP_LDI: reg_we = 1'b1;
            OP_ADD: begin
              alu_en = 1'b1;
              reg_we = 1'b1;
            end
            OP_JMP: begin
              set_pc  = 1'b1;
              pc_init = ir_q[3:0];
            end
            OP_JZ: begin
              if (bus.zero) begin
                set_pc  = 1'b1;
                pc_init = ir_q[3:0];
              end
            end
            OP_HLT: begin
              set_pc    = 1'b1;
              pc_init   = bus.PC_CURR;
              state_nxt = HALT;
            end
            default: ;
          endcase
        end
        HALT: begin
          set_pc  = 1'b1;
          pc_init = bus.PC_CURR;
          halted  = 1'b1;
        end
        default: state_nxt = FETCH;
      endcase
    end
  end

  assign bus.set_pc  = set_pc;
  assign bus.PC_INIT = pc_init;
  assign bus.alu_en  = alu_en;
  assign bus.reg_we  = reg_we;
  assign bus.halted  = halted;
  assign bus.OPCODE  = ir_q[7:4];
  assign bus.IMM     = ir_q[3:0];

endmodule

// File: tb/tb_ctrl_seq.sv
// Bench for ctrl_seq: a PC register and ROM close the loop; an ISA-level interpreter predicts each cycle.
module tb_ctrl_seq;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       zero_r = 1'b0;
  logic [3:0] pc_q = 4'hA;
  logic [7:0] rom [16];

  ctrl_seq_if bus ();

  ctrl_seq dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.master)
  );

  always #5 clk = ~clk;

  assign bus.PC_CURR = pc_q;
  assign bus.INSTR   = rom[pc_q];
  assign bus.zero    = zero_r;

  // Datapath PC: no enable, no reset; either load or increment every edge.
  always_ff @(posedge clk) begin
    pc_q <= bus.set_pc ? bus.PC_INIT : pc_q + 4'd1;
  end

  // Interpreter state: where the machine is in the instruction cycle.
  localparam int PH_FETCH = 0;
  localparam int PH_EXEC  = 1;
  localparam int PH_HALT  = 2;

  int         n_vec = 0;
  int         n_err = 0;
  int         phase = PH_FETCH;
  bit         m_known = 1'b0;
  logic [3:0] m_pc = 4'hA;
  logic [7:0] m_ir = 8'h00;

  task automatic check_val(input string tag, input logic [7:0] got, input logic [7:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h, expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  // One cycle: apply rst/zero, check outputs mid-cycle, advance interpreter on the edge.
  task automatic step(input bit r, input bit z);
    logic [3:0] op;
    logic [3:0] imm;
    logic       e_set;
    logic [3:0] e_init;
    logic       e_alu;
    logic       e_we;
    logic       e_halt;
    rst    = r;
    zero_r = z;
    #1;
    op     = m_ir[7:4];
    imm    = m_ir[3:0];
    e_set  = 1'b0;
    e_init = 4'h0;
    e_alu  = 1'b0;
    e_we   = 1'b0;
    e_halt = 1'b0;
    if (r) begin
      e_set = 1'b1;
    end else if (phase == PH_FETCH) begin
      e_set  = 1'b1;
      e_init = m_pc;
    end else if (phase == PH_EXEC) begin
      if (op == 4'h3 || (op == 4'h4 && z)) begin
        e_set  = 1'b1;
        e_init = imm;
      end else if (op == 4'hF) begin
        e_set  = 1'b1;
        e_init = m_pc;
      end
      e_alu = (op == 4'h2);
      e_we  = (op == 4'h1 || op == 4'h2);
    end else begin
      e_set  = 1'b1;
      e_init = m_pc;
      e_halt = 1'b1;
    end

    check_val("set_pc", {7'd0, bus.set_pc}, {7'd0, e_set});
    if (e_set) check_val("pc_init", {4'd0, bus.PC_INIT}, {4'd0, e_init});
    check_val("alu_en", {7'd0, bus.alu_en}, {7'd0, e_alu});
    check_val("reg_we", {7'd0, bus.reg_we}, {7'd0, e_we});
    check_val("halted", {7'd0, bus.halted}, {7'd0, e_halt});
    check_val("pc", {4'd0, pc_q}, {4'd0, m_pc});
    if (m_known) begin
      check_val("opcode", {4'd0, bus.OPCODE}, {4'd0, op});
      check_val("imm", {4'd0, bus.IMM}, {4'd0, imm});
    end

    @(posedge clk);
    if (r) begin
      m_pc    = 4'h0;
      m_ir    = 8'h00;
      phase   = PH_FETCH;
      m_known = 1'b1;
    end else if (phase == PH_FETCH) begin
      m_ir  = rom[m_pc];
      phase = PH_EXEC;
    end else if (phase == PH_EXEC) begin
      phase = PH_FETCH;
      if (op == 4'h3 || (op == 4'h4 && z)) m_pc = imm;
      else if (op == 4'hF) phase = PH_HALT;
      else m_pc = m_pc + 4'd1;
    end
    @(negedge clk);
  endtask

  task automatic clear_rom();
    for (int i = 0; i < 16; i++) rom[i] = 8'h00;
  endtask

  task automatic run(input int n, input bit z);
    for (int i = 0; i < n; i++) step(1'b0, z);
  endtask

  initial begin
    clear_rom();
    @(negedge clk);

    // Reset from PC=A: load 0 on the first rst edge.
    step(1'b1, 1'b0);
    run(2, 1'b0);

    // Sequential LDI/ADD/NOP.
    rom[0] = 8'h13; rom[1] = 8'h25; rom[2] = 8'h00;
    step(1'b1, 1'b0);
    run(8, 1'b0);

    // Wrap 15 -> 0 and JMP back to 15.
    clear_rom();
    rom[15] = 8'h00; rom[0] = 8'h3F;
    step(1'b1, 1'b0);
    run(14, 1'b0);

    // JZ taken and not taken.
    clear_rom();
    rom[2] = 8'h49;
    step(1'b1, 1'b0);
    run(8, 1'b1);
    step(1'b1, 1'b0);
    run(8, 1'b0);

    // Halt at 4, stay there, then reset out of it.
    clear_rom();
    rom[4] = 8'hF0;
    step(1'b1, 1'b0);
    run(24, 1'b0);
    step(1'b1, 1'b0);
    run(3, 1'b0);

    // Reset during EXEC of ADD.
    clear_rom();
    rom[0] = 8'h25;
    step(1'b1, 1'b0);
    step(1'b0, 1'b0);
    step(1'b1, 1'b0);
    run(4, 1'b0);

    // Random programs with random zero flag and sporadic resets.
    for (int k = 0; k < 25; k++) begin
      for (int i = 0; i < 16; i++) begin
        logic [3:0] op;
        case ($urandom_range(0, 7))
          0: op = 4'h0;
          1: op = 4'h1;
          2: op = 4'h2;
          3: op = 4'h3;
          4: op = 4'h4;
          5: op = ($urandom_range(0, 3) == 0) ? 4'hF : 4'h1;
          default: op = 4'($urandom_range(0, 15));
        endcase
        rom[i] = {op, 4'($urandom_range(0, 15))};
      end
      step(1'b1, 1'b0);
      for (int c = 0; c < 40; c++) begin
        step($urandom_range(0, 39) == 0, 1'($urandom_range(0, 1)));
      end
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
